// File: rtl/decrypt_pkg.sv
// Shared types and defaults for the cipher decrypt engine and its key remainder unit.
package decrypt_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 8;
  localparam int NUM_QUARTILES = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEYWAIT = 3'd1,
    S_KEYCALC = 3'd2,
    S_READ    = 3'd3,
    S_WAIT    = 3'd4,
    S_WRITE   = 3'd5,
    S_FIN     = 3'd6
  } state_t;
endpackage

// File: rtl/key_mod_unit.sv
// Iterative remainder ekey % mod by repeated subtraction, one subtraction per cycle.
module key_mod_unit
  import decrypt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] ekey,
  input  logic [DATA_W-1:0] mod,
  output logic [DATA_W-1:0] k,
  output logic              k_valid,
  output logic              div0
);

  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic              run_q, run_d;

  assign div0    = (mod == {DATA_W{1'b0}});
  assign k_valid = run_q && (r_q < mod_q);
  assign k       = r_q;

  // Next remainder: load on request, subtract while r >= mod, stop once the remainder is ready
  always_comb begin
    r_d   = r_q;
    mod_d = mod_q;
    run_d = run_q;
    if (load && !div0) begin
      r_d   = ekey;
      mod_d = mod;
      run_d = 1'b1;
    end else if (run_q && (r_q >= mod_q)) begin
      r_d = r_q - mod_q;
    end else begin
      run_d = 1'b0;
    end
  end

  // Remainder state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= {DATA_W{1'b0}};
      mod_q <= {DATA_W{1'b0}};
      run_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      mod_q <= mod_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/cipher_decrypt_engine.sv
// Decrypts cipher BRAM words as pt = ct - (ekey % mod) into the plaintext BRAM.
// Optional display tap enabled by defining DISP_TAP_EN.
module cipher_decrypt_engine
  import decrypt_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_LEN  = 30,
  parameter int BRAM_LAT = 1
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ekey,
  input  logic [DATA_W-1:0] mod,
  input  logic              key_valid,
  input  logic [ADDR_W-1:0] len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       progress,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int              BAR_W     = 4 * NUM_QUARTILES;
  localparam logic [BAR_W-1:0] BAR_FULL = {BAR_W{1'b1}};
  localparam logic [BAR_W-1:0] BAR_NONE = {BAR_W{1'b0}};
  localparam logic [ADDR_W-1:0] MAX_LEN_W = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [1:0]        WAIT_INIT = 2'(BRAM_LAT - 1);

  // Group q lights once 4*n >= q*total; q*total is built by repeated addition.
  function automatic logic [BAR_W-1:0] quart_bar(input logic [ADDR_W-1:0] n,
                                                 input logic [ADDR_W-1:0] total);
    logic [ADDR_W+2:0] lhs;
    logic [ADDR_W+2:0] acc;
    logic [BAR_W-1:0]  bar;
    lhs = {1'b0, n, 2'b00};
    acc = {(ADDR_W+3){1'b0}};
    bar = BAR_NONE;
    for (int q = 0; q < NUM_QUARTILES; q++) begin
      acc = acc + {3'b000, total};
      bar[4*q +: 4] = {4{lhs >= acc}};
    end
    return bar;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic [1:0]        wait_q, wait_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BAR_W-1:0]  progress_q, progress_d;

  logic              km_load_s;
  logic [DATA_W-1:0] km_k_s;
  logic              km_k_valid_s;
  logic              km_div0_s;
  logic [ADDR_W-1:0] idx_next_s;
  logic [ADDR_W-1:0] len_clamp_s;

  assign idx_next_s  = idx_q + ONE_A;
  assign len_clamp_s = (len > MAX_LEN_W) ? MAX_LEN_W : len;

  key_mod_unit #(.DATA_W(DATA_W)) u_key_mod (
    .clk     (CLK100MHZ),
    .reset   (reset),
    .load    (km_load_s),
    .ekey    (ekey),
    .mod     (mod),
    .k       (km_k_s),
    .k_valid (km_k_valid_s),
    .div0    (km_div0_s)
  );

  // Next-state and next-output logic; outputs are set up one cycle ahead so they register cleanly
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    k_d        = k_q;
    wait_d     = wait_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    progress_d = progress_q;
    km_load_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          progress_d = BAR_NONE;
          len_d      = len_clamp_s;
          idx_d      = {ADDR_W{1'b0}};
          busy_d     = 1'b1;
          state_d    = S_KEYWAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KEYWAIT: begin
        if (!key_valid) begin
          state_d = S_KEYWAIT;
        end else if (km_div0_s) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          km_load_s = 1'b1;
          state_d   = S_KEYCALC;
        end
      end
      S_KEYCALC: begin
        if (!km_k_valid_s) begin
          state_d = S_KEYCALC;
        end else if (len_q == {ADDR_W{1'b0}}) begin
          k_d        = km_k_s;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          progress_d = BAR_FULL;
          state_d    = S_FIN;
        end else begin
          k_d       = km_k_s;
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The last WAIT cycle is where rd_data is valid, so the word is captured here
        if (wait_q == 2'd0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rd_data - k_q;
          state_d   = S_WRITE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_WRITE: begin
        idx_d = idx_next_s;
        if (idx_next_s == len_q) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          progress_d = BAR_FULL;
          state_d    = S_FIN;
        end else begin
          progress_d = quart_bar(idx_next_s, len_q);
          rd_en_d    = 1'b1;
          rd_addr_d  = idx_next_s;
          state_d    = S_READ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= {ADDR_W{1'b0}};
      idx_q      <= {ADDR_W{1'b0}};
      k_q        <= {DATA_W{1'b0}};
      wait_q     <= 2'd0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= {ADDR_W{1'b0}};
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      progress_q <= BAR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      progress_q <= progress_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign progress = progress_q;

`ifdef DISP_TAP_EN
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;

  // Display tap mirrors each plaintext write
  always_comb begin
    disp_valid_d = wr_en_d;
    if (wr_en_d) begin
      disp_data_d = wr_data_d;
    end else begin
      disp_data_d = disp_data_q;
    end
  end

  // Display tap registers
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      disp_data_q  <= {DATA_W{1'b0}};
      disp_valid_q <= 1'b0;
    end else begin
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
`else
  assign disp_data  = {DATA_W{1'b0}};
  assign disp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_decrypt_engine.sv
// Scoreboard bench for cipher_decrypt_engine: random cipher data against a ct - ekey%mod reference.
module tb_cipher_decrypt_engine;
  localparam int MAXL = 30;

  logic        clk = 1'b0;
  logic        reset, start, key_valid;
  logic [7:0]  ekey, mod, len;
  logic        rd_en, wr_en, busy, done, err, disp_valid;
  logic [7:0]  rd_addr, wr_addr, wr_data, disp_data;
  logic [7:0]  rd_data = 8'h00;
  logic [15:0] progress;

  cipher_decrypt_engine dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .start      (start),
    .ekey       (ekey),
    .mod        (mod),
    .key_valid  (key_valid),
    .len        (len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .progress   (progress),
    .disp_data  (disp_data),
    .disp_valid (disp_valid)
  );

  always #5 clk = ~clk;

  // Cipher BRAM with one-cycle read latency
  logic [7:0] cmem [256];
  always @(posedge clk) if (rd_en) rd_data <= cmem[rd_addr];

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0, n_errors = 0;
  int wr_total = 0, rd_total = 0, wr_base = 0, rd_base = 0, cur_L = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_bar(input int n, input int L);
    logic [15:0] b;
    b = 16'h0000;
    for (int q = 1; q <= 4; q++) if (4 * n >= q * L) b[4*q-4 +: 4] = 4'hF;
    return b;
  endfunction

  // Reference: k = ekey % mod, L = min(len, MAX_LEN), pt[i] = (ct[i] - k) mod 256
  task automatic run(input int ek, input int md, input int ln, input bit mid_start);
    int L, k, lat, n;
    bit seen;
    L = (ln > MAXL) ? MAXL : ln;
    k = (md == 0) ? 0 : ek % md;
    if (md != 0)
      for (int i = 0; i < L; i++)
        exp_q.push_back(wr_t'{a: 8'(i), d: 8'((int'(cmem[i]) - k + 256) % 256)});
    lat = (md == 0) ? 1 : ((L == 0) ? ek / md + 2 : -1);
    wr_base = wr_total;
    rd_base = rd_total;
    cur_L   = L;
    @(negedge clk);
    ekey = 8'(ek); mod = 8'(md); len = 8'(ln); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len   = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    key_valid = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        key_valid = 1'b0;
        ekey = 8'($urandom);
        mod  = 8'($urandom);
      end
      if (mid_start) start = (n == 20);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (lat > 0) chk("done_latency", 32'(n), 32'(lat));
    chk("err_flag", 32'(err), (md == 0) ? 32'd1 : 32'd0);
    chk("progress_final", 32'(progress), (md == 0) ? 32'h0 : 32'hFFFF);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("write_count", 32'(wr_total - wr_base), (md == 0) ? 32'd0 : 32'(L));
    chk("read_count", 32'(rd_total - rd_base), (md == 0) ? 32'd0 : 32'(L));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    if (!seen) begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic fill_cipher();
    for (int i = 0; i < 256; i++) cmem[i] = 8'($urandom);
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rd_en) rd_total++;
          if (wr_en) begin
            chk("progress_bar", 32'(progress), 32'(exp_bar(wr_total - wr_base, cur_L)));
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 32'd1, 32'd0);
            end else begin
              mon_e = exp_q.pop_front();
              chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
              chk("wr_data", 32'(wr_data), 32'(mon_e.d));
`ifdef DISP_TAP_EN
              chk("disp_valid", 32'(disp_valid), 32'd1);
              chk("disp_data", 32'(disp_data), 32'(mon_e.d));
`else
              chk("disp_valid_off", 32'(disp_valid), 32'd0);
`endif
            end
            wr_total++;
          end
        end
      end
      begin : stimulus
        int md, wb;
        reset = 1'b1; start = 1'b0; key_valid = 1'b0;
        ekey = 8'h00; mod = 8'h00; len = 8'h00;
        fill_cipher();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_progress", 32'(progress), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        reset = 1'b0;

        cmem[0] = 8'h05; cmem[1] = 8'h02; cmem[2] = 8'h84;
        run(200, 7, 3, 1'b0);
        run(55, 0, 5, 1'b0);
        run(9, 4, 0, 1'b0);
        fill_cipher();
        run(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), 40, 1'b1);
        repeat (20) @(posedge clk);
        #1 chk("idle_after_ignored_start", 32'(busy), 32'd0);
        fill_cipher();
        run(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), 8, 1'b0);

        // Reset three writes into an 8-word run, then a fresh run completes
        fill_cipher();
        md = int'($urandom_range(1, 60));
        for (int i = 0; i < 8; i++)
          exp_q.push_back(wr_t'{a: 8'(i), d: 8'((int'(cmem[i]) - 123 % md + 256) % 256)});
        wr_base = wr_total; cur_L = 8;
        @(negedge clk);
        ekey = 8'd123; mod = 8'(md); len = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        wb = 0;
        while ((wr_total - wr_base) < 3 && wb < 3000) begin
          @(negedge clk); #1;
          wb++;
        end
        chk("third_write_seen", 32'(wr_total - wr_base), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_progress", 32'(progress), 32'd0);
        chk("abort_wr_data", 32'(wr_data), 32'd0);
        exp_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_fourth_write", 32'(wr_total - wr_base), 32'd3);
        chk("reset_beats_start", 32'(busy), 32'd0);
        fill_cipher();
        run(int'($urandom_range(0, 255)), md, 8, 1'b0);

        for (int t = 0; t < 6; t++) begin
          fill_cipher();
          run(int'($urandom_range(0, 255)), (t == 3) ? 0 : int'($urandom_range(1, 255)),
              int'($urandom_range(0, 35)), 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    join
  end

endmodule
